opsg_stereo: RTL and testbench

//  Parametrised successor PSG core: SN76489-compatible register file, three tone generators
//  and one noise generator. Adds a configurable LFSR (width/taps), a Game Gear-style stereo
//  pan register, a saturating per-side mixer and a sample_valid strobe.

---
 rtl/opsg_pkg.sv | 61 ++++++
 rtl/opsg_tone_gen.sv | 45 ++++
 rtl/opsg_stereo.sv | 184 ++++++++++++++++++
 tb/tb_opsg_stereo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/opsg_pkg.sv
`default_nettype none
//==[ opsg_pkg : latch/channel constants, noise reloads, 2 dB attenuation table | rev 1.0 ]==
package opsg_pkg;

  typedef enum logic [1:0] {
    CH_TONE1 = 2'd0,
    CH_TONE2 = 2'd1,
    CH_TONE3 = 2'd2,
    CH_NOISE = 2'd3
  } chan_e;

  typedef struct packed {
    chan_e ch;
    logic  vol;
  } latch_t;

  localparam latch_t     c_latch_rst = '{ch: CH_TONE1, vol: 1'b0};
  localparam int unsigned c_num_tones = 3;
  localparam logic [6:0] c_nrel_16   = 7'h10;
  localparam logic [6:0] c_nrel_32   = 7'h20;
  localparam logic [6:0] c_nrel_64   = 7'h40;

  function automatic logic [6:0] noise_reload(input logic [1:0] rate);
    logic [6:0] r;
    case (rate)
      2'd0:    r = c_nrel_16;
      2'd1:    r = c_nrel_32;
      2'd2:    r = c_nrel_64;
      default: r = c_nrel_16;
    endcase
    return r;
  endfunction

  // 10^(-att/10) in Q0.24, so amp = floor(max_volume * frac / 2^24).
  function automatic logic [31:0] amp(input logic [3:0] att, input int unsigned max_volume);
    logic [24:0] frac;
    logic [63:0] prod;
    case (att)
      4'd0:    frac = 25'd16777216;
      4'd1:    frac = 25'd13326616;
      4'd2:    frac = 25'd10585708;
      4'd3:    frac = 25'd8408526;
      4'd4:    frac = 25'd6679130;
      4'd5:    frac = 25'd5305421;
      4'd6:    frac = 25'd4214246;
      4'd7:    frac = 25'd3347495;
      4'd8:    frac = 25'd2659010;
      4'd9:    frac = 25'd2112126;
      4'd10:   frac = 25'd1677722;
      4'd11:   frac = 25'd1332662;
      4'd12:   frac = 25'd1058571;
      4'd13:   frac = 25'd840853;
      4'd14:   frac = 25'd667913;
      default: frac = 25'd0;
    endcase
    prod = 64'(max_volume) * 64'(frac);
    return 32'(prod >> 24);
  endfunction

endpackage
`default_nettype wire

// File: rtl/opsg_tone_gen.sv
`default_nettype none
//==[ opsg_tone_gen : 10-bit tone divider, toggles on reload, DC for period 0/1 | rev 1.0 ]==
module opsg_tone_gen (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tick_i,
  input  logic [9:0] period_i,
  output logic       out_o,
  output logic       toggle_o
);

  logic [9:0] cnt_q, cnt_d;
  logic       out_q, out_d;

  always_comb begin
    cnt_d    = cnt_q;
    out_d    = out_q;
    toggle_o = 1'b0;
    if (tick_i) begin
      if (period_i <= 10'd1) begin
        out_d = 1'b1;
      end else if (cnt_q == 10'd0) begin
        cnt_d    = period_i;
        out_d    = ~out_q;
        toggle_o = 1'b1;
      end else begin
        cnt_d = cnt_q - 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= 10'd0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule
`default_nettype wire

// File: rtl/opsg_stereo.sv
`default_nettype none
//==[ opsg_stereo : SN76489-compatible PSG, configurable LFSR, stereo pan, saturating mixer | rev 1.0 ]==
module opsg_stereo
  import opsg_pkg::*;
#(
  parameter int unsigned       CLK_DIV    = 4,
  parameter int unsigned       MAX_VOLUME = 2048,
  parameter int unsigned       OUT_W      = 16,
  parameter int unsigned       LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 'h0009
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             n_wr,
  input  logic             n_wr_stereo,
  input  logic [7:0]       data,
  output logic             ch1,
  output logic             ch2,
  output logic             ch3,
  output logic             ch4,
  output logic [OUT_W-1:0] audio_left,
  output logic [OUT_W-1:0] audio_right,
  output logic             sample_valid
);

  localparam int unsigned       c_pre_top = 16 * CLK_DIV - 1;
  localparam int unsigned       c_pre_w   = $clog2(16 * CLK_DIV);
  localparam logic [LFSR_W-1:0] c_seed    = {1'b1, {(LFSR_W-1){1'b0}}};
  localparam logic [33:0]       c_sat     = 34'((64'd1 << OUT_W) - 64'd1);

  logic [c_pre_w-1:0] presc_q;
  logic               w_tick, tick_q;
  logic               wr_prev_q, wrs_prev_q, w_wr, w_wrs;

  latch_t      latch_q, latch_d;
  logic [9:0]  period_q [c_num_tones];
  logic [9:0]  period_d [c_num_tones];
  logic [3:0]  att_q [4];
  logic [3:0]  att_d [4];
  logic [2:0]  nctrl_q, nctrl_d;
  logic [7:0]  stereo_q;
  chan_e       w_ch;
  logic        w_vol, w_noise_wr;

  logic [6:0]        ncnt_q, ncnt_d;
  logic              ntog_q, ntog_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              w_rise, w_fb;

  logic [2:0]       w_ch_out, w_tog;
  logic             w_unused_tog;
  logic [3:0]       w_ch_on;
  logic [33:0]      w_sum_l, w_sum_r;
  logic [OUT_W-1:0] audio_l_q, audio_r_q;
  logic             sv_q;

  assign w_tick = (presc_q == c_pre_w'(c_pre_top));
  // A write fires only on the first low cycle following a high one.
  assign w_wr   = ~n_wr & wr_prev_q;
  assign w_wrs  = ~n_wr_stereo & wrs_prev_q;

  for (genvar k = 0; k < c_num_tones; k++) begin : g_tone
    opsg_tone_gen u_tone (
      .clk      (clk),
      .n_rst    (n_rst),
      .tick_i   (w_tick),
      .period_i (period_q[k]),
      .out_o    (w_ch_out[k]),
      .toggle_o (w_tog[k])
    );
  end

  assign w_unused_tog = ^w_tog[1:0];

  always_comb begin
    latch_d    = latch_q;
    period_d   = period_q;
    att_d      = att_q;
    nctrl_d    = nctrl_q;
    w_noise_wr = 1'b0;
    w_ch       = data[7] ? chan_e'(data[6:5]) : latch_q.ch;
    w_vol      = data[7] ? data[4] : latch_q.vol;
    if (w_wr) begin
      if (data[7]) begin
        latch_d.ch  = chan_e'(data[6:5]);
        latch_d.vol = data[4];
      end
      if (w_vol) begin
        att_d[w_ch] = data[3:0];
      end else if (w_ch == CH_NOISE) begin
        nctrl_d    = data[2:0];
        w_noise_wr = 1'b1;
      end else if (data[7]) begin
        period_d[w_ch][3:0] = data[3:0];
      end else begin
        period_d[w_ch][9:4] = data[5:0];
      end
    end
  end

  // Rate 3 follows tone3's output rising; otherwise an internal divided toggle.
  always_comb begin
    ncnt_d = ncnt_q;
    ntog_d = ntog_q;
    w_rise = 1'b0;
    if (nctrl_q[1:0] == 2'b11) begin
      w_rise = w_tog[2] & ~w_ch_out[2];
    end else if (w_tick) begin
      if (ncnt_q == 7'd0) begin
        ncnt_d = noise_reload(nctrl_q[1:0]);
        ntog_d = ~ntog_q;
        w_rise = ~ntog_q;
      end else begin
        ncnt_d = ncnt_q - 7'd1;
      end
    end
    w_fb   = nctrl_q[2] ? ^(lfsr_q & LFSR_TAPS) : lfsr_q[0];
    lfsr_d = lfsr_q;
    if (w_noise_wr) begin
      lfsr_d = c_seed;
    end else if (w_rise) begin
      lfsr_d = {w_fb, lfsr_q[LFSR_W-1:1]};
    end
  end

  assign w_ch_on = {lfsr_q[0], w_ch_out};

  always_comb begin
    w_sum_l = 34'd0;
    w_sum_r = 34'd0;
    for (int n = 0; n < 4; n++) begin
      if (w_ch_on[n] && stereo_q[4+n]) w_sum_l = w_sum_l + 34'(amp(att_q[n], MAX_VOLUME));
      if (w_ch_on[n] && stereo_q[n])   w_sum_r = w_sum_r + 34'(amp(att_q[n], MAX_VOLUME));
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      wr_prev_q  <= 1'b1;
      wrs_prev_q <= 1'b1;
      latch_q    <= c_latch_rst;
      for (int k = 0; k < c_num_tones; k++) period_q[k] <= 10'd0;
      for (int k = 0; k < 4; k++) att_q[k] <= 4'hF;
      nctrl_q    <= 3'd0;
      stereo_q   <= 8'hFF;
      ncnt_q     <= 7'd0;
      ntog_q     <= 1'b0;
      lfsr_q     <= c_seed;
      audio_l_q  <= '0;
      audio_r_q  <= '0;
      sv_q       <= 1'b0;
    end else begin
      presc_q    <= w_tick ? '0 : presc_q + c_pre_w'(1);
      tick_q     <= w_tick;
      wr_prev_q  <= n_wr;
      wrs_prev_q <= n_wr_stereo;
      latch_q    <= latch_d;
      period_q   <= period_d;
      att_q      <= att_d;
      nctrl_q    <= nctrl_d;
      if (w_wrs) stereo_q <= data;
      ncnt_q     <= ncnt_d;
      ntog_q     <= ntog_d;
      lfsr_q     <= lfsr_d;
      sv_q       <= tick_q;
      if (tick_q) begin
        audio_l_q <= (w_sum_l > c_sat) ? {OUT_W{1'b1}} : w_sum_l[OUT_W-1:0];
        audio_r_q <= (w_sum_r > c_sat) ? {OUT_W{1'b1}} : w_sum_r[OUT_W-1:0];
      end
    end
  end

  assign ch1          = w_ch_out[0];
  assign ch2          = w_ch_out[1];
  assign ch3          = w_ch_out[2];
  assign ch4          = lfsr_q[0];
  assign audio_left   = audio_l_q;
  assign audio_right  = audio_r_q;
  assign sample_valid = sv_q;

endmodule
`default_nettype wire

// File: tb/tb_opsg_stereo.sv
`default_nettype none
//==[ tb_opsg_stereo : directed + random writes against a tick-level behavioural PSG model | rev 1.0 ]==
module tb_opsg_stereo;

  localparam int          CLK_DIV = 1;
  localparam int          MAXV    = 2048;
  localparam int          OW      = 12;
  localparam int          LW      = 16;
  localparam logic [15:0] TAPS    = 16'h0009;
  localparam int          PRE     = 16 * CLK_DIV;

  logic          clk = 1'b0, n_rst = 1'b0, n_wr = 1'b1, n_wr_stereo = 1'b1;
  logic [7:0]    data = 8'h00;
  logic          ch1, ch2, ch3, ch4, sample_valid;
  logic [OW-1:0] audio_left, audio_right;
  int            checks = 0, failures = 0, cyc_n = 0;

  opsg_stereo #(.CLK_DIV(CLK_DIV), .MAX_VOLUME(MAXV), .OUT_W(OW), .LFSR_W(LW), .LFSR_TAPS(TAPS)) dut (
    .clk(clk), .n_rst(n_rst), .n_wr(n_wr), .n_wr_stereo(n_wr_stereo), .data(data),
    .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4),
    .audio_left(audio_left), .audio_right(audio_right), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int amp_tab[16];
  int m_pre, m_per[3], m_cnt[3], m_att[4], m_stereo, m_ch, m_nctrl, m_ncnt, m_lfsr, m_left, m_right;
  bit m_out[3], m_vol, m_ntog, m_prev_wr, m_prev_st, m_tick_d, m_sv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_ch = 0; m_vol = 0; m_nctrl = 0; m_ncnt = 0; m_ntog = 0;
    m_lfsr = 1 << (LW - 1); m_stereo = 8'hFF; m_prev_wr = 1; m_prev_st = 1;
    m_tick_d = 0; m_sv = 0; m_left = 0; m_right = 0;
    for (int k = 0; k < 3; k++) begin m_per[k] = 0; m_cnt[k] = 0; m_out[k] = 0; end
    for (int k = 0; k < 4; k++) m_att[k] = 15;
  endtask

  function automatic int mix(input bit left);
    int s = 0;
    for (int n = 0; n < 4; n++) begin
      bit on, routed;
      on     = (n < 3) ? m_out[n] : m_lfsr[0];
      routed = left ? m_stereo[4+n] : m_stereo[n];
      if (on && routed) s += amp_tab[m_att[n]];
    end
    return (s > (1 << OW) - 1) ? (1 << OW) - 1 : s;
  endfunction

  task automatic model_edge(input bit nwr, input bit nws, input logic [7:0] d);
    bit wr, ws, tick, rise, t3rise;
    int mode, fb;
    wr = !nwr && m_prev_wr; ws = !nws && m_prev_st;
    m_prev_wr = nwr; m_prev_st = nws;
    tick  = (m_pre == PRE - 1);
    m_pre = tick ? 0 : m_pre + 1;
    m_sv  = m_tick_d;
    if (m_tick_d) begin m_left = mix(1); m_right = mix(0); end
    m_tick_d = tick;
    rise = 0; t3rise = 0; mode = m_nctrl & 3;
    if (tick) begin
      for (int k = 0; k < 3; k++) begin
        if (m_per[k] < 2) m_out[k] = 1;
        else if (m_cnt[k] == 0) begin
          m_cnt[k] = m_per[k];
          if (k == 2 && !m_out[k]) t3rise = 1;
          m_out[k] = !m_out[k];
        end else m_cnt[k]--;
      end
      if (mode == 3) rise = t3rise;
      else if (m_ncnt == 0) begin m_ncnt = 16 << mode; rise = !m_ntog; m_ntog = !m_ntog; end
      else m_ncnt--;
    end
    if (rise) begin
      fb = (m_nctrl & 4) ? int'(^(m_lfsr & int'(TAPS))) : (m_lfsr & 1);
      m_lfsr = (m_lfsr >> 1) | (fb << (LW - 1));
    end
    if (wr) begin
      if (d[7]) begin m_ch = int'(d[6:5]); m_vol = d[4]; end
      if (m_vol) m_att[m_ch] = int'(d[3:0]);
      else if (m_ch == 3) begin m_nctrl = int'(d[2:0]); m_lfsr = 1 << (LW - 1); end
      else if (d[7]) m_per[m_ch] = (m_per[m_ch] & 32'h3F0) | int'(d[3:0]);
      else m_per[m_ch] = (m_per[m_ch] & 32'hF) | (int'(d[5:0]) << 4);
    end
    if (ws) m_stereo = int'(d);
  endtask

  task automatic cyc(input bit nwr, input bit nws, input logic [7:0] d);
    logic [4+2*OW:0] obs, exp;
    @(negedge clk); n_wr = nwr; n_wr_stereo = nws; data = d;
    @(posedge clk); cyc_n++;
    if (n_rst) model_edge(nwr, nws, d);
    #1;
    obs = {ch1, ch2, ch3, ch4, sample_valid, audio_left, audio_right};
    exp = {m_out[0], m_out[1], m_out[2], m_lfsr[0], m_sv, OW'(m_left), OW'(m_right)};
    chk("cycle_model", 64'(obs), 64'(exp));
  endtask

  task automatic wr(input logic [7:0] d);  cyc(0, 1, d); cyc(1, 1, d); endtask
  task automatic wst(input logic [7:0] d); cyc(1, 0, d); cyc(1, 1, d); endtask
  task automatic idle(input int n);        repeat (n) cyc(1, 1, data); endtask

  task automatic async_reset();
    @(posedge clk); #3 n_rst = 1'b0; #1;
    chk("async_reset_clear", 64'({ch1, ch2, ch3, ch4, sample_valid, audio_left, audio_right}), 64'd0);
    model_reset();
    repeat (3) cyc(1, 1, 8'h00);
    #2 n_rst = 1'b1;
  endtask

  initial begin
    int t[3], nt, nsv;
    bit prev;
    for (int a = 0; a < 15; a++) amp_tab[a] = int'($floor(MAXV * $pow(10.0, -a / 10.0)));
    amp_tab[15] = 0;
    model_reset();
    repeat (3) cyc(1, 1, 8'h00);
    #2 n_rst = 1'b1;

    // Period 3, attenuation 0 on tone1
    wr(8'h83); wr(8'h00); wr(8'h90);
    nt = 0; nsv = 0; prev = ch1;
    for (int i = 0; i < 400; i++) begin
      cyc(1, 1, 8'h00);
      if (ch1 !== prev && nt < 3) begin t[nt] = cyc_n; nt++; end
      prev = ch1;
      if (i < 160 && sample_valid) nsv++;
      if (sample_valid) chk("tone1_audio", 64'(audio_left), ch1 ? 64'd2048 : 64'd0);
    end
    chk("tone1_toggle_interval", (nt == 3) ? 64'(t[2] - t[1]) : 64'hDEAD, 64'd64);
    chk("sample_valid_rate", 64'(nsv), 64'd10);

    // Period 1 is DC, then mute
    wr(8'h81); wr(8'h81); idle(40);
    for (int i = 0; i < 64; i++) begin cyc(1, 1, 8'h00); if (i % 16 == 0) chk("tone1_dc", 64'(ch1), 64'd1); end
    wr(8'h9F); idle(40);
    chk("muted_left", 64'(audio_left), 64'd0);

    // Pan tone1 to left only with every channel at full volume
    wst(8'h10); wr(8'h90); wr(8'hB0); wr(8'hD0); wr(8'hF0); idle(40);
    chk("pan_left", 64'(audio_left), 64'd2048);
    chk("pan_right", 64'(audio_right), 64'd0);

    // White noise reseed, then periodic 16-shift cycle
    cyc(0, 1, 8'hE4);
    chk("noise_seed_ch4", 64'(ch4), 64'd0);
    cyc(1, 1, 8'hE4); idle(3000);
    wr(8'hE0);
    nt = 0; prev = ch4;
    for (int i = 0; i < 20000 && nt < 2; i++) begin
      cyc(1, 1, 8'h00);
      if (ch4 && !prev) begin t[nt] = cyc_n; nt++; end
      prev = ch4;
    end
    chk("periodic_16_shifts", (nt == 2) ? 64'(t[1] - t[0]) : 64'hDEAD, 64'd8704);

    // Noise clocked by tone3 (period 2)
    wr(8'hC2); wr(8'h00); wr(8'hE7);
    nt = 0;
    begin
      bit p3, p4;
      p3 = ch3; p4 = ch4;
      for (int i = 0; i < 3000; i++) begin
        cyc(1, 1, 8'h00);
        if (ch4 !== p4) begin chk("noise_follows_tone3", 64'(ch3 && !p3), 64'd1); nt++; end
        p3 = ch3; p4 = ch4;
      end
    end
    chk("noise_tone3_active", 64'(nt > 0), 64'd1);

    // Saturation: three DC tones at full volume on both sides
    wst(8'hFF); wr(8'hC0); wr(8'h00); idle(40);
    chk("sat_left", 64'(audio_left), 64'hFFF);
    chk("sat_right", 64'(audio_right), 64'hFFF);

    // One write per low pulse, however long
    wst(8'h11);
    cyc(0, 1, 8'h9F); repeat (4) cyc(0, 1, 8'h90); cyc(1, 1, 8'h90); idle(40);
    chk("long_pulse_single_write", 64'(audio_left), 64'd0);

    // Randomized traffic with one asynchronous reset midway
    for (int it = 0; it < 2000; it++) begin
      logic [7:0] d;
      int sel;
      sel = $urandom_range(0, 9);
      d = 8'($urandom);
      if (!d[7] && $urandom_range(0, 1) == 1) d = d & 8'h01;
      if (it == 1000) begin
        async_reset();
        wr(8'h90); idle(40);
        chk("post_reset_stereo_all", 64'({audio_left, audio_right}), 64'({12'd2048, 12'd2048}));
      end else if (sel < 5) begin
        repeat ($urandom_range(1, 3)) cyc(0, 1, 8'($urandom));
        cyc(1, 1, d);
        data = d;
      end else if (sel == 5) begin
        wst(d);
      end else if (sel == 6) begin
        cyc(0, 0, d); cyc(1, 1, d);
      end else begin
        idle($urandom_range(1, 20));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
